// File: rtl/token_halver.sv
// -----------------------------------------------------------------------------
// token_halver
//
// Serial token halver. Tokens ('1' on a) are consumed in pairs. Every completed
// pair is buffered in a pending counter and handed downstream as one output
// token on b under a b_ready handshake.
//
// Optional feature macro: TOKEN_HALVER_TIMEOUT_EN
//   defined   - an unpaired token that sees TIMEOUT consecutive idle cycles is
//               dropped and the sticky orphan flag is raised.
//   undefined - an unpaired token waits indefinitely, no timer is built,
//               orphan is tied to 0 and TIMEOUT is ignored.
//
// Parameters:
//   MAX_PENDING - buffered output token capacity (>= 1)
//   TIMEOUT     - idle cycles an unpaired token may wait (>= 1)
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - asynchronous, active-high reset
//   a        - serial token input, one token per cycle when 1
//   b_ready  - downstream accepts a token this cycle
//   b        - output token valid (registered state only)
//   overflow - sticky: a completed pair was discarded at full capacity
//   orphan   - sticky: an unpaired token timed out
// -----------------------------------------------------------------------------
module token_halver #(
  parameter int MAX_PENDING = 200,
  parameter int TIMEOUT     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b_ready,
  output logic b,
  output logic overflow,
  output logic orphan
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } half_state_t;

  if (MAX_PENDING < 1) begin : g_bad_max_pending
    $error("token_halver: MAX_PENDING must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("token_halver: TIMEOUT must be >= 1");
  end

  half_state_t   state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          complete;
  logic          xfer;

`ifdef TOKEN_HALVER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          orphan_q, orphan_d;
  logic          drop;
`endif

  // Pairing FSM and idle timer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    complete = 1'b0;
`ifdef TOKEN_HALVER_TIMEOUT_EN
    timer_d  = timer_q;
    drop     = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (a) begin
          state_d = HALF;
`ifdef TOKEN_HALVER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      HALF: begin
        // A new token always pairs, even on the cycle the timer expires.
        if (a) begin
          state_d  = EMPTY;
          complete = 1'b1;
        end
`ifdef TOKEN_HALVER_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = EMPTY;
          drop    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef TOKEN_HALVER_TIMEOUT_EN
  assign orphan_d = orphan_q | drop;
`endif

  // Pending counter: a completion and a transfer in the same cycle cancel.
  // A completion at full capacity without a transfer loses the pair; since b
  // is high whenever pending is nonzero, pending never underflows.
  assign xfer = b & b_ready;

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (complete && !xfer) begin
      if (pending_q == PW'(MAX_PENDING)) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PW'(1);
      end
    end else if (xfer && !complete) begin
      pending_d = pending_q - PW'(1);
    end
  end

  // NOTE: asynchronous reset clears held and buffered tokens at once; all
  // state uses non-blocking assignments so every register samples the
  // pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef TOKEN_HALVER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      orphan_q <= orphan_d;
    end
  end

  assign orphan = orphan_q;
`else
  assign orphan = 1'b0;
`endif

  assign b        = (pending_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_token_halver.sv
// -----------------------------------------------------------------------------
// tb_token_halver
//
// Self-checking bench for token_halver (default parameters). A table of
// directed vectors, randomized traffic against a token-counting reference
// model, and hand-written sequences for capacity, simultaneous
// completion/transfer, timeout (when TOKEN_HALVER_TIMEOUT_EN is defined) and
// asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_token_halver;

  localparam int MAX_P = 200;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b_ready = 1'b0;
  logic b, overflow, orphan;

  token_halver #(
    .MAX_PENDING(MAX_P),
    .TIMEOUT    (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b_ready (b_ready),
    .b       (b),
    .overflow(overflow),
    .orphan  (orphan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int b_hits   = 0;

  // Reference model: counts of tokens rather than an FSM encoding.
  bit m_held;
  int m_idle;
  int m_pend;
  bit m_ovf;
  bit m_orph;

  typedef struct {
    bit a;
    bit br;
    bit b;
    bit ovf;
    bit orph;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0;
    m_idle = 0;
    m_pend = 0;
    m_ovf  = 0;
    m_orph = 0;
  endtask

  task automatic model_step(input bit ai, input bit bri);
    bit xfer;
    int comp;
    xfer = (m_pend != 0) && bri;
    comp = 0;
    if (ai) begin
      if (m_held) begin
        m_held = 0;
        comp   = 1;
      end else begin
        m_held = 1;
        m_idle = 0;
      end
    end else if (m_held) begin
`ifdef TOKEN_HALVER_TIMEOUT_EN
      m_idle++;
      if (m_idle >= TMO) begin
        m_held = 0;
        m_orph = 1;
      end
`endif
    end
    m_pend = m_pend + comp - (xfer ? 1 : 0);
    if (m_pend > MAX_P) begin
      m_pend = MAX_P;
      m_ovf  = 1;
    end
  endtask

  // One clock cycle: drive at the falling edge, sample at the next one.
  task automatic cycle(input bit ai, input bit bri);
    a       = ai;
    b_ready = bri;
    model_step(ai, bri);
    @(posedge clk);
    @(negedge clk);
    check("b", b, (m_pend != 0) ? 1 : 0);
    check("overflow", overflow, m_ovf);
    check("orphan", orphan, m_orph);
    if (b) b_hits++;
  endtask

  // Asynchronous reset pulse asserted away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    a       = 1'b0;
    b_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_b", b, 0);
    check("rst_overflow", overflow, 0);
    check("rst_orphan", orphan, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;

    // a=1,1 then idle; then a steady run of 1s with b_ready held high.
    vecs[0] = '{a:1, br:1, b:0, ovf:0, orph:0};
    vecs[1] = '{a:1, br:1, b:1, ovf:0, orph:0};
    vecs[2] = '{a:0, br:1, b:0, ovf:0, orph:0};
    vecs[3] = '{a:0, br:1, b:0, ovf:0, orph:0};
    vecs[4] = '{a:1, br:1, b:0, ovf:0, orph:0};
    vecs[5] = '{a:1, br:1, b:1, ovf:0, orph:0};
    vecs[6] = '{a:1, br:1, b:0, ovf:0, orph:0};
    vecs[7] = '{a:1, br:1, b:1, ovf:0, orph:0};
    vecs[8] = '{a:0, br:0, b:1, ovf:0, orph:0};
    vecs[9] = '{a:0, br:1, b:0, ovf:0, orph:0};

    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].a, vecs[i].br);
      check($sformatf("vec%0d_b", i), b, vecs[i].b);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
      check($sformatf("vec%0d_orphan", i), orphan, vecs[i].orph);
    end

    // Randomized traffic; sparse tokens make idle stretches likely.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
    end

    // Capacity: fill, simultaneous completion and transfer, overflow, drain.
    do_reset();
    for (int i = 0; i < 2 * MAX_P; i++) cycle(1, 0);
    check("full_b", b, 1);
    check("full_overflow", overflow, 0);
    cycle(1, 0);
    cycle(1, 1);
    check("simul_overflow", overflow, 0);
    cycle(1, 0);
    cycle(1, 0);
    check("ovf_set", overflow, 1);
    cnt = 0;
    for (int i = 0; i < MAX_P + 100; i++) begin
      if (b) cnt++;
      cycle(0, 1);
    end
    check("drain_count", cnt, MAX_P);
    check("ovf_sticky", overflow, 1);
    cycle(1, 1);
    cycle(1, 1);
    check("ovf_traffic_b", b, 1);
    check("ovf_still_set", overflow, 1);

`ifdef TOKEN_HALVER_TIMEOUT_EN
    // Timeout boundary: 7 idle cycles still pair, 8 drop the token.
    do_reset();
    b_hits = 0;
    cycle(1, 1);
    for (int i = 0; i < TMO - 1; i++) cycle(0, 1);
    cycle(1, 1);
    cycle(0, 1);
    cycle(0, 1);
    check("tmo_pair_hits", b_hits, 1);
    check("tmo_pair_orphan", orphan, 0);
    cycle(1, 1);
    for (int i = 0; i < TMO - 1; i++) cycle(0, 1);
    check("tmo_before_drop", orphan, 0);
    cycle(0, 1);
    check("tmo_drop", orphan, 1);
    cycle(1, 1);
    cycle(0, 1);
    check("tmo_no_b", b_hits, 1);
    cycle(1, 1);
    cycle(0, 1);
    check("tmo_new_half_pairs", b_hits, 2);
    for (int i = 0; i < 4; i++) cycle(1, 1);
    check("orphan_sticky", orphan, 1);
`else
    // Without the timer an unpaired token waits indefinitely.
    do_reset();
    b_hits = 0;
    cycle(1, 1);
    for (int i = 0; i < 50; i++) cycle(0, 1);
    cycle(1, 1);
    cycle(0, 1);
    cycle(0, 1);
    check("notmo_hits", b_hits, 1);
    check("notmo_orphan", orphan, 0);
`endif

    // Asynchronous reset mid-stream with pending=5 and a half token held.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0);
    cycle(1, 0);
    check("pre_rst_b", b, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_b", b, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_orphan", orphan, 0);
    @(negedge clk);
    rst = 1'b0;
    b_hits = 0;
    cycle(1, 1);
    cycle(1, 1);
    cycle(0, 1);
    cycle(0, 1);
    check("post_rst_hits", b_hits, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
